hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RV32I core. Computes operand forwarding selects, load-use stalls, and branch/jump flushes. Sequences the multi-cycle data-memory handshake that freezes the pipeline while a memory-stage access waits for acknowledge. Drives the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/core_pkg.sv | 35 +++
 rtl/hazard_fwd_unit.sv | 43 ++++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core's hazard/stall control.
//   state_t      : memory-wait FSM states (RUN, WAIT)
//   FWD_*        : execute operand forwarding selects
//   RES_LOAD     : ResultSrcE encoding that marks a load in execute
//   fwd_sel()    : forwarding priority for one execute source operand
package core_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    // The memory stage holds the younger result, so it wins over writeback.
    // x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [4:0] rd_w,
        input logic       we_m,
        input logic       we_w
    );
        if (we_m && rd_m != 5'd0 && rd_m == rs)
            return FWD_MEM;
        else if (we_w && rd_w != 5'd0 && rd_w == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational operand forwarding and load-use detection.
// Ports:
//   rs1D, rs2D           decode-stage sources
//   rs1E, rs2E, rdE      execute-stage sources / destination
//   ResultSrcE           execute result select (RES_LOAD marks a load)
//   rdM, rdW             memory / writeback destinations
//   RegWriteM, RegWriteW register-write enables
//   ForwardAE, ForwardBE operand selects for the execute stage
//   lw_stall             load in execute feeds an instruction in decode
module hazard_fwd_unit
    import core_pkg::*;
(
    input  logic [4:0] rs1D,
    input  logic [4:0] rs2D,
    input  logic [4:0] rs1E,
    input  logic [4:0] rs2E,
    input  logic [4:0] rdE,
    input  logic [1:0] ResultSrcE,
    input  logic [4:0] rdM,
    input  logic [4:0] rdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       lw_stall
);

    logic [1:0][4:0] rs_e;
    logic [1:0][1:0] fwd;

    assign rs_e = {rs2E, rs1E};

    for (genvar i = 0; i < 2; i++) begin : g_op
        assign fwd[i] = fwd_sel(rs_e[i], rdM, rdW, RegWriteM, RegWriteW);
    end

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];

    assign lw_stall = (ResultSrcE == RES_LOAD) && (rdE != 5'd0) &&
                      ((rdE == rs1D) || (rdE == rs2D));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage RV32I core.
// Forwarding selects, load-use stalls, branch/jump flushes, and the
// data-memory wait sequencer with timeout abort.
// Optional feature macro: HAZARD_PERF_EN (saturating performance counters;
// without it the counter ports read 0).
// Ports:
//   clk, reset (async, active-low)
//   rs1D/rs2D, rs1E/rs2E/rdE, ResultSrcE, PCSrcE, rdM/rdW,
//   RegWriteM/RegWriteW, MemAccessM, dmem_ack, err_clr       : inputs
//   ForwardAE/ForwardBE                                      : operand selects
//   StallF/StallD/StallE/StallM, FlushD/FlushE/FlushW        : pipeline control
//   mem_err                                                  : sticky timeout flag
//   lw_stall_cnt, mem_stall_cnt, flush_cnt                   : perf counters
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemAccessM,
    input  logic             dmem_ack,
    input  logic             err_clr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] lw_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Last wait count before the access is given up.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       lw_stall;
    logic       mem_stall;
    logic       abort;

    hazard_fwd_unit u_fwd (
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .rs1E       (rs1E),
        .rs2E       (rs2E),
        .rdE        (rdE),
        .ResultSrcE (ResultSrcE),
        .rdM        (rdM),
        .rdW        (rdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .lw_stall   (lw_stall)
    );

    // The abort cycle drops the stall so the pipeline moves on; FlushW
    // kills the failed access's writeback.
    assign abort     = (state == WAIT) && !dmem_ack && (wait_cnt == WAIT_LAST);
    assign mem_stall = MemAccessM && !dmem_ack && !abort;

    assign StallF = lw_stall | mem_stall;
    assign StallD = lw_stall | mem_stall;
    assign StallE = mem_stall;
    assign StallM = mem_stall;
    // Execute is frozen during a wait, so a pending redirect is simply
    // deferred to the release cycle.
    assign FlushD = PCSrcE & ~mem_stall;
    assign FlushE = (lw_stall | PCSrcE) & ~mem_stall;
    assign FlushW = mem_stall | abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (MemAccessM && !dmem_ack) begin
                        state    <= WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                WAIT: begin
                    if (dmem_ack || abort)
                        state <= RUN;
                    else
                        wait_cnt <= wait_cnt + 8'd1;
                end
                default: state <= RUN;
            endcase
            // Set has priority over clear.
            if (abort)
                mem_err <= 1'b1;
            else if (err_clr)
                mem_err <= 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] lw_q, ms_q, fl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lw_q <= '0;
            ms_q <= '0;
            fl_q <= '0;
        end else begin
            if (lw_stall && !mem_stall && lw_q != '1)
                lw_q <= lw_q + CNT_W'(1);
            if (mem_stall && ms_q != '1)
                ms_q <= ms_q + CNT_W'(1);
            if (FlushD && fl_q != '1)
                fl_q <= fl_q + CNT_W'(1);
        end
    end

    assign lw_stall_cnt  = lw_q;
    assign mem_stall_cnt = ms_q;
    assign flush_cnt     = fl_q;
`else
    assign lw_stall_cnt  = '0;
    assign mem_stall_cnt = '0;
    assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by a
// randomized run, all checked against a cycle-level reference model.
module tb_hazard_ctrl;

    localparam int MT = 4;
    localparam int CW = 6;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, RegWriteM, RegWriteW, MemAccessM, dmem_ack, err_clr;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [CW-1:0] lw_stall_cnt, mem_stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: whether an access is outstanding, how many
    // cycles it has waited, the sticky error, and event tallies.
    bit m_wait;
    int m_waited;
    bit m_err;
    int m_lw, m_ms, m_fl;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .rdM(rdM), .rdW(rdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemAccessM(MemAccessM),
        .dmem_ack(dmem_ack), .err_clr(err_clr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_err(mem_err),
        .lw_stall_cnt(lw_stall_cnt), .mem_stall_cnt(mem_stall_cnt),
        .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_fwd(input logic [4:0] rs);
        if (RegWriteM && rdM != 0 && rdM == rs) return 2;
        if (RegWriteW && rdW != 0 && rdW == rs) return 1;
        return 0;
    endfunction

    function automatic bit ref_lw();
        return ResultSrcE == 2'd1 && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    endfunction

    function automatic bit ref_abort();
        return m_wait && !dmem_ack && m_waited == MT - 1;
    endfunction

    function automatic bit ref_ms();
        return MemAccessM && !dmem_ack && !ref_abort();
    endfunction

    function automatic int expc(input int v);
        return PERF ? v : 0;
    endfunction

    task automatic model_clear();
        m_wait = 0; m_waited = 0; m_err = 0;
        m_lw = 0; m_ms = 0; m_fl = 0;
    endtask

    task automatic check_all();
        bit lw, ms, ab;
        lw = ref_lw(); ms = ref_ms(); ab = ref_abort();
        chk("ForwardAE", ForwardAE, ref_fwd(rs1E));
        chk("ForwardBE", ForwardBE, ref_fwd(rs2E));
        chk("StallF", StallF, lw | ms);
        chk("StallD", StallD, lw | ms);
        chk("StallE", StallE, ms);
        chk("StallM", StallM, ms);
        chk("FlushD", FlushD, PCSrcE & !ms);
        chk("FlushE", FlushE, (lw | PCSrcE) & !ms);
        chk("FlushW", FlushW, ms | ab);
        chk("mem_err", mem_err, m_err);
        chk("lw_stall_cnt", lw_stall_cnt, expc(m_lw));
        chk("mem_stall_cnt", mem_stall_cnt, expc(m_ms));
        chk("flush_cnt", flush_cnt, expc(m_fl));
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_tick();
        bit lw, ms, ab;
        if (!reset) begin
            model_clear();
            return;
        end
        lw = ref_lw(); ms = ref_ms(); ab = ref_abort();
        if (lw && !ms && m_lw < CMAX) m_lw++;
        if (ms && m_ms < CMAX) m_ms++;
        if (PCSrcE && !ms && m_fl < CMAX) m_fl++;
        if (ab) m_err = 1;
        else if (err_clr) m_err = 0;
        if (!m_wait) begin
            if (MemAccessM && !dmem_ack) begin
                m_wait = 1;
                m_waited = 1;
            end
        end else if (dmem_ack || ab) begin
            m_wait = 0;
        end else begin
            m_waited++;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        check_all();
        model_tick();
        @(negedge clk);
    endtask

    task automatic idle();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemAccessM = 0; dmem_ack = 0; err_clr = 0;
    endtask

    initial begin
        int m0, l0;
        idle();
        model_clear();
        @(negedge clk);
        step();
        reset = 1'b1;
        step();

        // Forwarding priority.
        rs1E = 5; rdM = 5; RegWriteM = 1; rdW = 5; RegWriteW = 1;
        rs2E = 7;
        #1 chk("fwdA_mem", ForwardAE, 2'b10);
        step();
        rdM = 0; rdW = 7; rs2E = 7; rs1E = 7;
        #1 chk("fwdA_wb_rdM0", ForwardAE, 2'b01);
        chk("fwdB_wb", ForwardBE, 2'b01);
        step();

        // Load-use: one bubble.
        idle(); l0 = m_lw;
        ResultSrcE = 2'b01; rdE = 3; rs2D = 3;
        #1 chk("lw_stallF", StallF, 1);
        chk("lw_flushE", FlushE, 1);
        chk("lw_stallE", StallE, 0);
        step();
        idle();
        #1 chk("lw_cnt", lw_stall_cnt, expc(l0 + 1));
        step();

        // Ack after three wait cycles.
        idle(); m0 = m_ms;
        MemAccessM = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("ack3_stallM", StallM, 1);
            step();
        end
        dmem_ack = 1;
        #1 chk("ack3_release", StallM, 0);
        step();
        idle();
        #1 chk("ack3_err", mem_err, 0);
        chk("ack3_cnt", mem_stall_cnt, expc(m0 + 3));
        step();

        // Timeout with no ack.
        idle(); MemAccessM = 1;
        for (int i = 0; i < MT - 1; i++) begin
            #1 chk("to_stallM", StallM, 1);
            step();
        end
        #1 chk("to_abort_stallF", StallF, 0);
        chk("to_abort_flushW", FlushW, 1);
        chk("to_abort_err0", mem_err, 0);
        step();
        idle();
        #1 chk("to_err_set", mem_err, 1);
        step();
        err_clr = 1;
        step();
        err_clr = 0;
        #1 chk("to_err_clr", mem_err, 0);
        step();

        // Redirect during a memory wait is deferred to the ack cycle.
        idle(); MemAccessM = 1; PCSrcE = 1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("br_wait_flushD", FlushD, 0);
            chk("br_wait_flushE", FlushE, 0);
            step();
        end
        dmem_ack = 1;
        #1 chk("br_rel_flushD", FlushD, 1);
        chk("br_rel_flushE", FlushE, 1);
        step();
        idle();
        step();

        // Reset in the middle of a wait, with mem_err already set.
        MemAccessM = 1;
        for (int i = 0; i < MT + 2; i++) step();
        #1 reset = 1'b0;
        model_clear();
        #1 chk("rst_err", mem_err, 0);
        chk("rst_mscnt", mem_stall_cnt, 0);
        chk("rst_stall_run", StallM, 1);
        dmem_ack = 1;
        #1 chk("rst_ack_nostall", StallM, 0);
        step();
        reset = 1'b1;
        #1 chk("rst_rel_nostall", StallF, 0);
        step();

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            rs1D = 5'($urandom_range(0, 3));
            rs2D = 5'($urandom_range(0, 3));
            rs1E = 5'($urandom_range(0, 3));
            rs2E = 5'($urandom_range(0, 3));
            rdE  = 5'($urandom_range(0, 3));
            rdM  = 5'($urandom_range(0, 3));
            rdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            RegWriteM  = 1'($urandom);
            RegWriteW  = 1'($urandom);
            MemAccessM = 1'($urandom);
            dmem_ack   = ($urandom_range(0, 3) == 0);
            err_clr    = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
